// File: rtl/wishbone_ram_slave.sv
// Wishbone classic slave backed by a 32-bit word RAM with programmable wait states.
// Optional macro WB_SLAVE_ERR_EN adds o_wb_err for out-of-window addresses and empty byte selects.
module wishbone_ram_slave #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_wb_addr,
   input  logic [31:0] i_wb_data,
   input  logic        i_wb_we,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_stb,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_data,
   output logic        o_wb_ack
`ifdef WB_SLAVE_ERR_EN
   ,
   output logic        o_wb_err
`endif
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_ack;
   logic [31:0]        r_data;
   logic [ADDR_W-1:0]  r_idx;
   logic [31:0]        r_wdata;
   logic               r_we;
   logic [3:0]         r_sel;
   logic [31:0]        r_mem [DEPTH];

   logic               w_latch;
   logic               w_ack_nxt;
   logic               w_err_nxt;
   logic               w_rd_nxt;
   logic               w_wr;
   logic               w_bad;
   logic               w_unused;

`ifdef WB_SLAVE_ERR_EN
   logic               r_err;
   logic               r_in_win;

   assign w_bad    = !r_in_win || (r_sel == 4'b0000);
   assign o_wb_err = r_err;
   assign w_unused = ^{i_wb_addr[1:0]};
`else
   assign w_bad    = 1'b0;
   assign w_unused = ^{i_wb_addr[1:0], i_wb_addr[31:ADDR_W+2], BASE_ADDR[0], w_err_nxt};
`endif

   assign o_wb_data = r_data;
   assign o_wb_ack  = r_ack;

   // Next-state and registered-output decode
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      w_rd_nxt    = 1'b0;
      w_wr        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_wb_cyc && i_wb_stb) begin
               w_latch = 1'b1;
               if (WAIT_CYCLES > 0) begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = CNT_LOAD;
               end else begin
                  w_state_nxt = S_ACK;
               end
            end
         end
         S_WAIT: begin
            if (!i_wb_cyc) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_ACK;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         S_ACK: begin
            w_state_nxt = S_IDLE;
            if (w_bad) begin
               w_err_nxt = 1'b1;
            end else begin
               w_ack_nxt = 1'b1;
               w_wr      = r_we;
               w_rd_nxt  = !r_we;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ack   <= 1'b0;
         r_data  <= '0;
`ifdef WB_SLAVE_ERR_EN
         r_err   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ack   <= w_ack_nxt;
         r_data  <= w_rd_nxt ? r_mem[r_idx] : 32'h0;
`ifdef WB_SLAVE_ERR_EN
         r_err   <= w_err_nxt;
`endif
      end
   end

   // Request capture; later bus changes cannot disturb the transfer in flight
   always_ff @(posedge i_clk) begin
      if (w_latch && !i_rst) begin
         r_idx   <= i_wb_addr[ADDR_W+1:2];
         r_wdata <= i_wb_data;
         r_we    <= i_wb_we;
         r_sel   <= i_wb_sel;
`ifdef WB_SLAVE_ERR_EN
         r_in_win <= (i_wb_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
`endif
      end
   end

   // Byte-lane write at the acknowledge edge; contents survive reset
   always_ff @(posedge i_clk) begin
      if (w_wr && !i_rst) begin
         for (int b = 0; b < 4; b++) begin
            if (r_sel[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: doc/wishbone_ram_slave.md
WISHBONE_RAM_SLAVE -- requirements
Module: wishbone_ram_slave

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; memory depth = 2**ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 1, extra wait states inserted before ack (range 0..15).
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, byte base address of the window; must be aligned to 4*2**ADDR_W.
REQ-004 Single clock i_clk; reset i_rst is synchronous and active-high.
REQ-005 i_clk  input  1  system clock, all logic on rising edge.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_wb_addr  input  32  byte address from master.
REQ-008 i_wb_data  input  32  write data from master.
REQ-009 i_wb_we  input  1  1 = write, 0 = read.
REQ-010 i_wb_sel  input  4  byte lane enables; bit n covers data[8n+7:8n].
REQ-011 i_wb_stb  input  1  strobe.
REQ-012 i_wb_cyc  input  1  bus cycle valid.
REQ-013 o_wb_data  output  32  read data, valid only while o_wb_ack is high.
REQ-014 o_wb_ack  output  1  single-cycle transfer acknowledge, registered.
REQ-015 o_wb_err  output  1  error terminate; present only with WB_SLAVE_ERR_EN (REQ-032).

Function
REQ-016 FSM states: S_IDLE, S_WAIT, S_ACK; encoding 2 bits; illegal states return to S_IDLE.
REQ-017 S_IDLE: on i_wb_cyc & i_wb_stb, latch addr/data/we/sel; go S_WAIT if WAIT_CYCLES>0 (counter loaded WAIT_CYCLES-1), else S_ACK.
REQ-018 S_WAIT: counter decrements each cycle; at 0 go S_ACK.
REQ-019 S_ACK: o_wb_ack high for exactly one cycle, then S_IDLE unconditionally.
REQ-020 Latency: request sampled at edge N -> o_wb_ack high during cycle after edge N+1+WAIT_CYCLES... i.e. ack visible WAIT_CYCLES+1 cycles after sampling.
REQ-021 o_wb_ack never high on two consecutive cycles; a stb still high in the S_IDLE cycle after ack starts a new transaction.
REQ-022 Word index = latched addr[ADDR_W+1:2]; addr[1:0] ignored.
REQ-023 Write: memory updated at the same edge that sets o_wb_ack, only lanes with sel bit set; o_wb_data = 0 during write ack.
REQ-024 Read: o_wb_data = full 32-bit word (sel ignored) during ack; 0 in all other cycles.
REQ-025 Abort: i_wb_cyc low while in S_WAIT -> S_IDLE next edge, no ack, no write.
REQ-026 Inputs changing after latch do not affect the transaction in progress.

Reset
REQ-027 i_rst high at an edge: state S_IDLE, counter 0, o_wb_ack 0, o_wb_data 0, o_wb_err 0.
REQ-028 Reset has priority over any pending write; a write coinciding with reset is discarded.
REQ-029 Memory contents are not reset.
REQ-030 Request present while i_rst high is ignored; first sampling at first edge with i_rst low.

Configuration
REQ-031 Macro WB_SLAVE_ERR_EN selects address/select checking.
REQ-032 Defined: o_wb_err exists; latched addr outside [BASE_ADDR, BASE_ADDR+4*2**ADDR_W) or sel==4'b0000 -> o_wb_err high one cycle in place of ack, same latency, no write, o_wb_data 0.
REQ-033 Not defined: no o_wb_err port; address upper bits ignored (wraps modulo depth); sel==0 write acks with no memory change.

Verification
REQ-034 WAIT_CYCLES=1: write 0xDEADBEEF sel=F to 0x10, then read 0x10 -> ack 2 cycles after each request, read data 0xDEADBEEF.
REQ-035 Byte write 0x000000AA sel=4'b0001 onto word 0x12345678 -> readback 0x123456AA.
REQ-036 WAIT_CYCLES=0, back-to-back reads with stb held -> ack every second cycle, never two consecutive.
REQ-037 WAIT_CYCLES=3, write then cyc dropped after 2 cycles -> no ack, readback shows old value.
REQ-038 i_rst asserted in S_WAIT of a write -> no ack, memory unchanged, o_wb_data 0.
REQ-039 WB_SLAVE_ERR_EN, ADDR_W=10, read 0x1000 -> o_wb_err 1 one cycle, ack 0; without macro, same read returns word 0.
